// File: rtl/online_relu_early_term.sv
// ReLU stage for an MSDF signed-digit stream: resolves the sign at the first non-zero digit,
// forwards non-negative streams, flags negative ones early and assembles the value by OTFC.
module online_relu_early_term #(
    parameter int N_DIGITS = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                z_p,
    input  logic                z_n,
    output logic                y_p,
    output logic                y_n,
    output logic                y_valid,
    output logic                terminate,
    output logic                done,
    output logic [N_DIGITS-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_POS, S_NEG} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_idx, w_cnt_nxt;
    logic [N_DIGITS-1:0] r_q, r_qm, w_qb, w_qmb, w_q_nxt, w_qm_nxt;
    logic                r_pend;
    logic                w_d_pos, w_d_neg, w_fin_now, w_go, w_zrules, w_proc, w_to_neg, w_last;
    logic                w_y_valid_nxt, w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_d_pos   = z_p & ~z_n;
        w_d_neg   = z_n & ~z_p;
        w_fin_now = ((r_state == S_ZERO) || (r_state == S_POS)) && (r_cnt == LAST);
        // A start arriving with the last digit is held one cycle so that stream completes first.
        w_go      = (start && !w_fin_now) || r_pend;
        w_zrules  = w_go || (r_state == S_ZERO);
        w_proc    = w_zrules || (r_state == S_POS);
        w_to_neg  = w_zrules && w_d_neg;
        w_idx     = w_go ? '0 : r_cnt;
        w_last    = (w_idx == LAST);
        if (!w_proc)        w_state_nxt = S_IDLE;
        else if (w_to_neg)  w_state_nxt = S_NEG;
        else if (w_last)    w_state_nxt = S_IDLE;
        else if (w_zrules)  w_state_nxt = w_d_pos ? S_POS : S_ZERO;
        else                w_state_nxt = S_POS;
    end

    always_comb begin
        w_qb  = w_go ? '0 : r_q;
        w_qmb = w_go ? '1 : r_qm;
        if (w_d_pos) begin
            w_q_nxt  = {w_qb[N_DIGITS-2:0], 1'b1};
            w_qm_nxt = {w_qb[N_DIGITS-2:0], 1'b0};
        end else if (w_d_neg) begin
            w_q_nxt  = {w_qmb[N_DIGITS-2:0], 1'b1};
            w_qm_nxt = {w_qmb[N_DIGITS-2:0], 1'b0};
        end else begin
            w_q_nxt  = {w_qb[N_DIGITS-2:0], 1'b0};
            w_qm_nxt = {w_qmb[N_DIGITS-2:0], 1'b1};
        end
        w_y_valid_nxt = w_proc && !w_to_neg;
        w_done_nxt    = w_proc && (w_to_neg || w_last);
        w_cnt_nxt     = (w_y_valid_nxt && !w_last) ? w_idx + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_qm      <= '1;
            y_p       <= 1'b0;
            y_n       <= 1'b0;
            y_valid   <= 1'b0;
            done      <= 1'b0;
            terminate <= 1'b0;
            result    <= '0;
        end else begin
            r_pend  <= start && w_fin_now;
            r_cnt   <= w_cnt_nxt;
            y_valid <= w_y_valid_nxt;
            y_p     <= w_y_valid_nxt && w_d_pos;
            y_n     <= w_y_valid_nxt && w_d_neg;
            done    <= w_done_nxt;
            if (w_proc) begin
                r_q  <= w_to_neg ? '0 : w_q_nxt;
                r_qm <= w_to_neg ? '1 : w_qm_nxt;
            end
            if (w_done_nxt) result <= w_to_neg ? '0 : w_q_nxt;
            if (w_to_neg)  terminate <= 1'b1;
            else if (w_go) terminate <= 1'b0;
        end
    end
endmodule

// File: tb/tb_online_relu_early_term.sv
// Bench for online_relu_early_term: table of directed streams, multi-cycle corner sequences
// and random streams checked against an arithmetic model of the signed-digit value.
module tb_online_relu_early_term;
    localparam int N = 16;

    logic        clk, rst, start, z_p, z_n;
    logic        y_p, y_n, y_valid, terminate, done;
    logic [15:0] result;

    int n_chk  = 0;
    int n_pass = 0;
    int cur_c  = 0;

    typedef struct {
        logic [31:0] codes;
        logic [15:0] res;
        int          negidx;
    } vec_t;

    vec_t tab [9];

    online_relu_early_term #(.N_DIGITS(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .z_p(z_p), .z_n(z_n),
        .y_p(y_p), .y_n(y_n), .y_valid(y_valid), .terminate(terminate),
        .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cur_c, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value of the stream as an integer (MSB digit weight 2^(N-1)); a stream whose first
    // non-zero digit is -1 is negative and reports that digit's index.
    function automatic void model(input logic [31:0] codes, output logic [15:0] res,
                                  output int negidx);
        int v;
        int d;
        bit seen;
        logic [1:0] cd;
        v = 0; seen = 1'b0; negidx = N; res = '0;
        for (int k = 0; k < N; k++) begin
            cd = codes[2*k +: 2];
            d = (cd == 2'b10) ? 1 : (cd == 2'b01) ? -1 : 0;
            if (!seen && d != 0) begin
                seen = 1'b1;
                if (d < 0) begin
                    negidx = k;
                    return;
                end
            end
            v = 2 * v + d;
        end
        res = v[15:0];
    endfunction

    function automatic logic [31:0] rand_codes();
        logic [31:0] c;
        int r;
        c = '0;
        for (int k = 0; k < N; k++) begin
            r = $urandom_range(0, 9);
            c[2*k +: 2] = (r < 3) ? 2'b00 : (r < 5) ? 2'b11 : (r < 8) ? 2'b10 : 2'b01;
        end
        return c;
    endfunction

    task automatic run_stream(input logic [31:0] codes, input logic [15:0] exp_res,
                              input int negidx, input int tail, input int abort_at,
                              input bit drv_start, input bit start_last,
                              input bit exp_done0, input logic [15:0] exp_res0);
        int cycles;
        int done_at;
        int k;
        bit ev;
        logic [1:0] dig;
        cycles  = (abort_at < N) ? abort_at : N + tail;
        done_at = (negidx < N) ? negidx + 1 : N;
        for (int c = 0; c < cycles; c++) begin
            step();
            start = (c == 0 && drv_start) || (c == N - 1 && start_last);
            if (c < N) {z_p, z_n} = codes[2*c +: 2];
            else       {z_p, z_n} = 2'($urandom_range(0, 3));
            @(negedge clk);
            cur_c = c;
            if (c == 0) begin
                chk("done_at_start", 32'(done), 32'(exp_done0));
                if (exp_done0) chk("prev_result", 32'(result), 32'(exp_res0));
            end else begin
                k   = c - 1;
                ev  = (k < negidx);
                dig = 2'b00;
                if (k < N) dig = codes[2*k +: 2];
                chk("y_valid", 32'(y_valid), 32'(ev));
                chk("y_p", 32'(y_p), 32'(ev && dig == 2'b10));
                chk("y_n", 32'(y_n), 32'(ev && dig == 2'b01));
                chk("done", 32'(done), 32'(c == done_at));
                chk("terminate", 32'(terminate), 32'(negidx < N && c >= negidx + 1));
                if (c >= done_at) chk("result", 32'(result), 32'(exp_res));
            end
        end
    endtask

    initial begin
        logic [31:0] codes;
        logic [15:0] res, pres;
        int          ni;
        bit          b2b, sl, pd, psl;

        tab[0] = '{32'h0000_0006, 16'h4000, N};
        tab[1] = '{32'hAAAA_AA90, 16'h0000, 2};
        tab[2] = '{32'hCCCC_CCCC, 16'h0000, N};
        tab[3] = '{32'hAAAA_AAAA, 16'hFFFF, N};
        tab[4] = '{32'h6666_6666, 16'h5555, N};
        tab[5] = '{32'hAAAA_AAA9, 16'h0000, 0};
        tab[6] = '{32'h0000_0002, 16'h8000, N};
        tab[7] = '{32'h8000_0000, 16'h0001, N};
        tab[8] = '{32'h4000_0000, 16'h0000, 15};

        rst = 1'b1; start = 1'b0; z_p = 1'b0; z_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_y_p", 32'(y_p), 32'd0);
        chk("rst_y_n", 32'(y_n), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_terminate", 32'(terminate), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        step();
        rst = 1'b0;

        foreach (tab[i])
            run_stream(tab[i].codes, tab[i].res, tab[i].negidx, 2, N, 1'b1, 1'b0, 1'b0, 16'h0);

        // Restart during a positive stream: first stream is abandoned without done.
        codes = rand_codes();
        codes[1:0] = 2'b10;
        model(codes, res, ni);
        run_stream(codes, res, ni, 2, 5, 1'b1, 1'b0, 1'b0, 16'h0);
        codes = rand_codes();
        model(codes, res, ni);
        run_stream(codes, res, ni, 2, N, 1'b1, 1'b0, 1'b0, 16'h0);

        // Back-to-back with start in the cycle after the last digit.
        run_stream(tab[3].codes, tab[3].res, tab[3].negidx, 0, N, 1'b1, 1'b0, 1'b0, 16'h0);
        run_stream(tab[0].codes, tab[0].res, tab[0].negidx, 2, N, 1'b1, 1'b0, 1'b1, 16'hFFFF);

        // Start coinciding with the last digit: new stream begins one cycle later.
        run_stream(tab[4].codes, tab[4].res, tab[4].negidx, 0, N, 1'b1, 1'b1, 1'b0, 16'h0);
        run_stream(tab[6].codes, tab[6].res, tab[6].negidx, 2, N, 1'b0, 1'b0, 1'b1, 16'h5555);

        pd = 1'b0; psl = 1'b0; pres = '0;
        for (int i = 0; i < 40; i++) begin
            codes = rand_codes();
            model(codes, res, ni);
            b2b = (i != 39) && (ni >= N - 1) && ($urandom_range(0, 2) == 0);
            sl  = b2b && ($urandom_range(0, 1) == 1);
            run_stream(codes, res, ni, b2b ? 0 : 2, N, !psl, sl, pd, pres);
            pd = b2b; psl = sl; pres = res;
        end

        // Asynchronous reset between clock edges in the middle of a stream.
        run_stream(tab[3].codes, tab[3].res, tab[3].negidx, 2, N, 1'b1, 1'b0, 1'b0, 16'h0);
        step(); start = 1'b1; {z_p, z_n} = 2'b10;
        step(); start = 1'b0; {z_p, z_n} = 2'b00;
        step();
        cur_c = -1;
        chk("pre_rst_y_valid", 32'(y_valid), 32'd1);
        chk("pre_rst_result", 32'(result), 32'hFFFF);
        #2 rst = 1'b1;
        #1;
        chk("arst_y_p", 32'(y_p), 32'd0);
        chk("arst_y_valid", 32'(y_valid), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_terminate", 32'(terminate), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_y_valid", 32'(y_valid), 32'd0);
        run_stream(tab[6].codes, tab[6].res, tab[6].negidx, 2, N, 1'b1, 1'b0, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
